// File: rtl/ring_freq_counter.sv
// Gated edge counter for a divided ring-oscillator: counts synchronized rising
// edges of osc_in over a programmable clk window. Define RING_FREQ_SATURATE_EN to saturate.
module ring_freq_counter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic              ready_q;
  logic [GATE_W-1:0] win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              edge_pulse;
  logic              accept;

  // sync_q[1:0] is the metastability synchronizer; sync_q[2] delays for edge detect.
  assign edge_pulse = sync_q[1] & ~sync_q[2];
  // ready_q masks start for the first cycle after reset release.
  assign accept     = ready_q & start & (state_q != GATE);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = GATE;
          win_d   = (gate_len == '0) ? GATE_W'(1) : gate_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      GATE: begin
        if (edge_pulse) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
`ifdef RING_FREQ_SATURATE_EN
            cnt_d = CNT_MAX;
`else
            cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Last window cycle: the edge seen this cycle is folded into the result.
        if (win_q == GATE_W'(1)) begin
          state_d  = DONE;
          result_d = cnt_d;
        end else begin
          win_d = win_q - GATE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      ready_q  <= 1'b0;
      win_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q  <= state_d;
      sync_q   <= {sync_q[1:0], osc_in};
      ready_q  <= 1'b1;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == GATE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: doc/ring_freq_counter.md
RING_FREQ_COUNTER -- requirements
Module: ring_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, edge-count and result width; legal range 4..24.
REQ-002 SHALL have parameter GATE_W, default 16, gate-length width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port osc_in  input  1  divided ring-oscillator output, asynchronous to clk.
REQ-006 SHALL have port start  input  1  measurement request, sampled on posedge clk.
REQ-007 SHALL have port gate_len  input  GATE_W  window length in clk cycles, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while the window is open.
REQ-009 SHALL have port done  output  1  one-cycle pulse at measurement completion.
REQ-010 SHALL have port result  output  CNT_W  edge count of the last completed measurement.
REQ-011 SHALL have port overflow  output  1  edge count exceeded 2^CNT_W-1 during the last measurement.

Function
REQ-012 SHALL pass osc_in through a 2-flop synchronizer, then a third flop; edge pulse = stage2 & ~stage3.
REQ-013 SHALL count an osc_in rising edge as an edge pulse 3 clk cycles after the first posedge clk that samples it high.
REQ-014 SHALL implement states IDLE, GATE, DONE.
REQ-015 SHALL accept start in IDLE or DONE: next cycle state=GATE, window counter loaded, edge counter cleared, overflow cleared.
REQ-016 SHALL treat gate_len=0 as 1.
REQ-017 SHALL keep the window open for exactly max(gate_len,1) cycles, starting the cycle after start is accepted; count every edge pulse in those cycles.
REQ-018 SHALL ignore start while in GATE; captured gate_len is unaffected by later changes.
REQ-019 SHALL, in the cycle after the last window cycle, enter DONE, load result with the final count including any edge in the last window cycle, and assert done for exactly that cycle.
REQ-020 SHALL hold result and overflow in DONE and IDLE until the next accepted start.
REQ-021 SHALL return from DONE to IDLE after one cycle unless start is high in that cycle, in which case it enters GATE directly.
REQ-022 SHALL drive busy=1 only in GATE.
REQ-023 SHALL, when the edge counter is at 2^CNT_W-1 and an edge pulse arrives, set overflow (sticky for the measurement), with counter behaviour per REQ-027/028.

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-GATE), go to IDLE immediately and clear all synchronizer flops, the edge counter, the window counter, result, and overflow.
REQ-025 SHALL hold outputs at reset: busy=0, done=0, result=0, overflow=0.
REQ-026 SHALL ignore start in the first cycle after rst_n deasserts; it is accepted from the second cycle onward.

Configuration
REQ-027 SHALL, with RING_FREQ_SATURATE_EN defined, hold the edge counter at 2^CNT_W-1 on overflow.
REQ-028 SHALL, without RING_FREQ_SATURATE_EN, wrap the edge counter modulo 2^CNT_W on overflow; overflow is set in both builds.

Verification
REQ-029 SHALL verify: osc_in period 8 clk (rising edge synchronized to clk), gate_len=64 -> done after 65 cycles, result=8, overflow=0.
REQ-030 SHALL verify: osc_in held 0, gate_len=100 -> result=0; gate_len=0 -> busy high for 1 cycle, done on the next cycle.
REQ-031 SHALL verify: CNT_W=4, osc_in period 2 clk, gate_len=64 -> 32 edges; default build gives result=0, overflow=1; RING_FREQ_SATURATE_EN build gives result=15, overflow=1.
REQ-032 SHALL verify: start pulsed mid-GATE with gate_len=5 while the window was started with 64 -> ignored, window length stays 64, result is unchanged by the second start.
REQ-033 SHALL verify: rst_n low mid-GATE -> busy=0, result=0, and no done pulse in the same cycle; a new start afterwards measures correctly.
REQ-034 SHALL verify: start held high continuously with gate_len=16 -> back-to-back measurements, one done pulse every 17 cycles, no IDLE cycle between them.
